// File: rtl/sha256_pkg.sv
// sha256_pkg: shared digest sizing, encoder FSM encodings and ASCII constants.
package sha256_pkg;
    localparam int DIGEST_W = 256;
    localparam int NCHAR = DIGEST_W / 4;
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SEND     = 2'b01,
        COMPLETE = 2'b10
    } enc_state_t;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_UA = 8'h41;
endpackage

// File: rtl/hex_ascii_mapping.sv
// hex_ascii_mapping: combinational nibble to ASCII hex character.
module hex_ascii_mapping
    import sha256_pkg::*;
#(
    parameter bit UPPERCASE = 1'b0
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    always_comb
        ascii = (nibble < 4'd10) ? ASCII_0 + {4'h0, nibble}
                                 : (UPPERCASE ? ASCII_UA : ASCII_LA) + {4'h0, nibble} - 8'd10;
endmodule

// File: rtl/digest_output_encoder.sv
// digest_output_encoder: streams a captured digest as ASCII hex chars over valid/ready.
// Define SEG7_EN to add an active-low 7-segment view of the current nibble on seg_out.
module digest_output_encoder
    import sha256_pkg::*;
#(
    parameter int DIGEST_W  = sha256_pkg::DIGEST_W,
    parameter bit UPPERCASE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hash_done,
    input  logic [DIGEST_W-1:0] digest,
    input  logic                char_ready,
    output logic                char_valid,
    output logic [7:0]          char_out,
    output logic [5:0]          char_index,
    output logic                busy,
    output logic                done
`ifdef SEG7_EN
    ,
    output logic [6:0]          seg_out
`endif
);
    localparam int NCH = DIGEST_W / 4;

    enc_state_t          state, nxt;
    logic                hd_q, start, hs, last;
    logic [DIGEST_W-1:0] sr;
    logic [5:0]          idx;
    logic [7:0]          ascii;

    assign start = hash_done & ~hd_q;
    assign hs    = char_valid & char_ready;
    assign last  = idx == 6'(NCH - 1);

    hex_ascii_mapping #(.UPPERCASE(UPPERCASE)) u_map (
        .nibble(sr[DIGEST_W-1 -: 4]),
        .ascii (ascii)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = start ? SEND : IDLE;
            SEND:     nxt = (hs && last) ? COMPLETE : SEND;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hd_q  <= 1'b0;
            sr    <= '0;
            idx   <= '0;
        end else begin
            state <= nxt;
            hd_q  <= hash_done;
            if (state == IDLE && start) begin
                sr  <= digest;
                idx <= '0;
            end else if (hs) begin
                sr  <= sr << 4;
                idx <= last ? idx : idx + 6'd1;
            end
        end
    end

    assign char_valid = state == SEND;
    assign busy       = state == SEND;
    assign done       = state == COMPLETE;
    assign char_out   = char_valid ? ascii : 8'h00;
    assign char_index = idx;

`ifdef SEG7_EN
    // Segments g..a, index by nibble value (entry 0 is the rightmost)
    localparam logic [15:0][6:0] SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    assign seg_out = char_valid ? SEG[sr[DIGEST_W-1 -: 4]] : 7'h7F;
`endif
endmodule

// File: tb/tb_digest_output_encoder.sv
// tb_digest_output_encoder: scoreboard bench, lowercase and uppercase instances share stimulus.
module tb_digest_output_encoder;
    localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] PAT = {4{64'h0123456789abcdef}};

    logic clk = 0, rst_n = 0, hash_done = 0, char_ready = 1;
    logic [255:0] dig = '0;
    logic char_valid, busy, done, uv, ubusy, udone;
    logic [7:0] char_out, uout;
    logic [5:0] char_index, uidx;
`ifdef SEG7_EN
    logic [6:0] seg_out, useg;
`endif

    typedef struct {
        int         idx;
        logic [3:0] nib;
        logic [7:0] lc;
        logic [7:0] uc;
    } ent_t;
    ent_t sb[$];

    int total = 0, bad = 0, done_cnt = 0, vcount = 0, rmode = 0;
    logic [7:0] log_c [64];

    always #5 clk = ~clk;

    digest_output_encoder dut (
        .clk(clk), .rst_n(rst_n), .hash_done(hash_done), .digest(dig), .char_ready(char_ready),
        .char_valid(char_valid), .char_out(char_out), .char_index(char_index), .busy(busy), .done(done)
`ifdef SEG7_EN
        , .seg_out(seg_out)
`endif
    );

    digest_output_encoder #(.UPPERCASE(1'b1)) dut_u (
        .clk(clk), .rst_n(rst_n), .hash_done(hash_done), .digest(dig), .char_ready(char_ready),
        .char_valid(uv), .char_out(uout), .char_index(uidx), .busy(ubusy), .done(udone)
`ifdef SEG7_EN
        , .seg_out(useg)
`endif
    );

    function automatic logic [7:0] m(input logic [3:0] x, input bit up);
        return (x < 4'd10) ? 8'h30 + {4'h0, x} : (up ? 8'h37 : 8'h57) + {4'h0, x};
    endfunction

`ifdef SEG7_EN
    function automatic logic [6:0] seg7(input logic [3:0] x);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[x];
    endfunction
`endif

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        char_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every handshake, checks hold during stalls
    logic stall = 0;
    logic [7:0] p_out;
    logic [5:0] p_idx;
    always @(negedge clk) begin
        ent_t e;
        if (!rst_n) stall = 0;
        else begin
            if (stall) begin
                chk("hold_valid", char_valid, 1);
                chk("hold_char", char_out, p_out);
                chk("hold_idx", char_index, p_idx);
            end
            if (char_valid) vcount++;
            if (done) done_cnt++;
`ifdef SEG7_EN
            if (!char_valid) chk("seg_idle", seg_out, 7'h7F);
`endif
            if (char_valid && char_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_char idx=%0d char=%0h required=none", char_index, char_out);
                end else begin
                    e = sb.pop_front();
                    chk("char", char_out, e.lc);
                    chk("idx", char_index, e.idx);
                    chk("uchar", uout, e.uc);
`ifdef SEG7_EN
                    chk("seg", seg_out, seg7(e.nib));
`endif
                    log_c[char_index] = char_out;
                end
            end
            stall = char_valid && !char_ready;
            p_out = char_out;
            p_idx = char_index;
        end
    end

    task automatic load(input logic [255:0] d);
        ent_t e;
        for (int i = 0; i < 64; i++) begin
            e.idx = i;
            e.nib = d[255-4*i -: 4];
            e.lc  = m(e.nib, 0);
            e.uc  = m(e.nib, 1);
            sb.push_back(e);
        end
    endtask

    task automatic xfer(input logic [255:0] d, input int mode, input int g, output int n);
        bit gl = 0;
        load(d);
        @(posedge clk);
        #1;
        vcount = 0;
        dig = d;
        rmode = mode;
        hash_done = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (g >= 0 && !gl && char_valid && char_index == 6'(g)) begin
                gl = 1;
                @(posedge clk); #1 hash_done = 0;
                @(posedge clk); #1 hash_done = 1;
            end
        end while (!done && n < 3000);
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after", busy, 0);
        chk("sb_drained", sb.size(), 0);
        rmode = 0;
    endtask

    task automatic idle2();
        @(posedge clk);
        #1 hash_done = 0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int n, dc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", char_valid, 0);
        chk("rst_char", char_out, 0);
        chk("rst_idx", char_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1;
        repeat (2) @(posedge clk);

        xfer(ABC, 0, -1, n);
        chk("latency_to_done", n, 66);
        chk("valid_cycles", vcount, 64);
        chk("done_count", done_cnt, 1);
        chk("abc_c0", log_c[0], 8'h62);
        chk("abc_c1", log_c[1], 8'h61);
        chk("abc_c2", log_c[2], 8'h37);
        chk("abc_c3", log_c[3], 8'h38);
        chk("abc_c62", log_c[62], 8'h61);
        chk("abc_c63", log_c[63], 8'h64);
        idle2();

        load(ABC);
        @(posedge clk);
        #1 hash_done = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(char_valid && char_index == 6'd10) && n < 500);
        chk("reached_idx10", char_index, 10);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", char_valid, 0);
        chk("mid_rst_char", char_out, 0);
        chk("mid_rst_idx", char_index, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_uvalid", uv, 0);
        sb.delete();
        hash_done = 0;
        dc = done_cnt;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (5) @(negedge clk);
        chk("no_done_after_rst", done_cnt, dc);
        chk("idle_after_rst", char_valid, 0);

        xfer(ABC, 1, -1, n);
        chk("bp_valid_cycles_ge64", vcount >= 64, 1);
        chk("bp_c63", log_c[63], 8'h64);
        idle2();

        dc = done_cnt;
        xfer(PAT, 0, 20, n);
        repeat (200) @(negedge clk);
        chk("held_single_done", done_cnt, dc + 1);
        chk("held_no_restart", char_valid, 0);
        idle2();

        xfer({256{1'b1}}, 0, -1, n);
        chk("allf_lc_c0", log_c[0], 8'h66);
        idle2();
        xfer('0, 0, -1, n);
        chk("zero_c63", log_c[63], 8'h30);
        idle2();
`ifdef SEG7_EN
        xfer({64{4'h8}}, 0, -1, n);
        idle2();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
